uart_rx_frame_ctrl: RTL and testbench

Receive-side controller that sequences the UART byte receiver.
- Drives the receiver's byte handshake.
- Hunts for a frame header and parses the length field, payload and checksum.
- Uses the receiver's idle-frame pulse to abort incomplete frames.
- Stores the payload in an internal buffer and holds the link off (back-pressure) until the host releases the frame.
- Sits between the UART byte receiver and the command decoder / register host.

---
 rtl/uart_rx_frame_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Receive-side frame parser: HEADER, LEN, payload, CHK into a buffer held until host release.
// Optional statistics counters enabled by defining UART_RX_FRAME_CTRL_STATS_EN.
module uart_rx_frame_ctrl #(
  parameter int          MAX_LEN = 32,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int          AW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_data_valid,
  output logic          rx_data_ready,
  input  logic          rx_frame_ack,
  output logic          frm_done,
  output logic [7:0]    frm_len,
  output logic          frm_err,
  output logic [1:0]    frm_err_code,
  input  logic [AW-1:0] frm_rd_addr,
  output logic [7:0]    frm_rd_data,
`ifdef UART_RX_FRAME_CTRL_STATS_EN
  output logic [15:0]   good_cnt,
  output logic [15:0]   err_cnt,
  input  logic          stats_clr,
`endif
  input  logic          frm_release
);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_LEN  = 3'd1,
    S_PAY  = 3'd2,
    S_CHK  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [AW:0] MAX_ADDR = (AW+1)'(MAX_LEN);

  state_t       state_r, state_s, state_nxt_s;
  logic [7:0]   acc_r, acc_s;
  logic [7:0]   len_r, len_s;
  logic [7:0]   idx_r, idx_s;
  logic         ready_r, done_r, err_r;
  logic [7:0]   frm_len_r, rd_data_r;
  logic [1:0]   code_r, code_s, code_fin_s;
  logic         xfer_s, done_s, err_s, err_fin_s, wr_en_s, ack_abort_s;
  logic [7:0]   mem_r [MAX_LEN];

  assign xfer_s = rx_data_valid && ready_r;

  // Byte-driven parser transitions; the idle ack is applied afterwards against the resulting state.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    len_s   = len_r;
    idx_s   = idx_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    code_s  = 2'b00;
    wr_en_s = 1'b0;
    case (state_r)
      S_HUNT: begin
        if (xfer_s && (rx_data == HEADER)) begin
          state_s = S_LEN;
          acc_s   = 8'd0;
        end else begin
          state_s = S_HUNT;
        end
      end
      S_LEN: begin
        if (xfer_s) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            err_s   = 1'b1;
            code_s  = 2'b01;
            state_s = S_HUNT;
          end else begin
            len_s   = rx_data;
            acc_s   = rx_data;
            idx_s   = 8'd0;
            state_s = S_PAY;
          end
        end else begin
          state_s = S_LEN;
        end
      end
      S_PAY: begin
        if (xfer_s) begin
          wr_en_s = 1'b1;
          acc_s   = acc_r + rx_data;
          idx_s   = idx_r + 8'd1;
          if ((idx_r + 8'd1) == len_r) begin
            state_s = S_CHK;
          end else begin
            state_s = S_PAY;
          end
        end else begin
          state_s = S_PAY;
        end
      end
      S_CHK: begin
        if (xfer_s) begin
          if (rx_data == acc_r) begin
            done_s  = 1'b1;
            state_s = S_HOLD;
          end else begin
            err_s   = 1'b1;
            code_s  = 2'b10;
            state_s = S_HUNT;
          end
        end else begin
          state_s = S_CHK;
        end
      end
      S_HOLD: begin
        if (frm_release) begin
          state_s = S_HUNT;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s = S_HUNT;
      end
    endcase
  end

  // A frame still open after the byte is processed is aborted as truncated.
  assign ack_abort_s = rx_frame_ack &&
                       ((state_s == S_LEN) || (state_s == S_PAY) || (state_s == S_CHK));
  assign state_nxt_s = ack_abort_s ? S_HUNT : state_s;
  assign err_fin_s   = err_s || ack_abort_s;
  assign code_fin_s  = ack_abort_s ? 2'b11 : code_s;

  // Parser state, accumulator, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_HUNT;
      acc_r     <= 8'd0;
      len_r     <= 8'd0;
      idx_r     <= 8'd0;
      ready_r   <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      code_r    <= 2'b00;
      frm_len_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_s;
      len_r   <= len_s;
      idx_r   <= idx_s;
      ready_r <= (state_nxt_s != S_HOLD);
      done_r  <= done_s;
      err_r   <= err_fin_s;
      if (err_fin_s) begin
        code_r <= code_fin_s;
      end
      if (done_s) begin
        frm_len_r <= len_r;
      end
    end
  end

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[idx_r[AW-1:0]] <= rx_data;
    end
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 8'd0;
    end else if ({1'b0, frm_rd_addr} < MAX_ADDR) begin
      rd_data_r <= mem_r[frm_rd_addr];
    end else begin
      rd_data_r <= 8'd0;
    end
  end

  assign rx_data_ready = ready_r;
  assign frm_done      = done_r;
  assign frm_err       = err_r;
  assign frm_err_code  = code_r;
  assign frm_len       = frm_len_r;
  assign frm_rd_data   = rd_data_r;

`ifdef UART_RX_FRAME_CTRL_STATS_EN
  logic [15:0] good_cnt_r, err_cnt_r;

  // Saturating frame counters; clear has priority over increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_r <= 16'd0;
      err_cnt_r  <= 16'd0;
    end else if (stats_clr) begin
      good_cnt_r <= 16'd0;
      err_cnt_r  <= 16'd0;
    end else begin
      if (done_r && (good_cnt_r != 16'hFFFF)) begin
        good_cnt_r <= good_cnt_r + 16'd1;
      end
      if (err_r && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign good_cnt = good_cnt_r;
  assign err_cnt  = err_cnt_r;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed self-checking bench for uart_rx_frame_ctrl (default parameters).
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_data_valid = 1'b0;
  logic       rx_data_ready;
  logic       rx_frame_ack = 1'b0;
  logic       frm_done;
  logic [7:0] frm_len;
  logic       frm_err;
  logic [1:0] frm_err_code;
  logic [4:0] frm_rd_addr = 5'd0;
  logic [7:0] frm_rd_data;
  logic       frm_release = 1'b0;
`ifdef UART_RX_FRAME_CTRL_STATS_EN
  logic [15:0] good_cnt, err_cnt;
  logic        stats_clr = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .rx_frame_ack(rx_frame_ack),
    .frm_done(frm_done), .frm_len(frm_len), .frm_err(frm_err), .frm_err_code(frm_err_code),
    .frm_rd_addr(frm_rd_addr), .frm_rd_data(frm_rd_data),
`ifdef UART_RX_FRAME_CTRL_STATS_EN
    .good_cnt(good_cnt), .err_cnt(err_cnt), .stats_clr(stats_clr),
`endif
    .frm_release(frm_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte transfer; outputs sampled 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_data_valid = 1'b1;
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
    frm_rd_addr = a;
    tick();
    check(tag, {24'd0, frm_rd_data}, {24'd0, exp});
  endtask

  task automatic release_frame();
    frm_release = 1'b1;
    tick();
    frm_release = 1'b0;
    check("ready_after_release", {31'd0, rx_data_ready}, 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_ready", {31'd0, rx_data_ready}, 32'd0);
    check("rst_done",  {31'd0, frm_done}, 32'd0);
    check("rst_len",   {24'd0, frm_len}, 32'd0);
    check("rst_err",   {31'd0, frm_err}, 32'd0);
    check("rst_code",  {30'd0, frm_err_code}, 32'd0);
    check("rst_rd",    {24'd0, frm_rd_data}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("ready_first_cycle", {31'd0, rx_data_ready}, 32'd1);

    // good frame with leading junk
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    check("t1_no_done_early", {31'd0, frm_done}, 32'd0);
    send(8'h69);
    check("t1_done",  {31'd0, frm_done}, 32'd1);
    check("t1_err",   {31'd0, frm_err}, 32'd0);
    check("t1_len",   {24'd0, frm_len}, 32'd3);
    check("t1_ready", {31'd0, rx_data_ready}, 32'd0);
    tick();
    check("t1_done_pulse", {31'd0, frm_done}, 32'd0);
    rd(5'd0, 8'h11, "t1_buf0");
    rd(5'd1, 8'h22, "t1_buf1");
    rd(5'd2, 8'h33, "t1_buf2");

    // back-pressure in hold: 55 offered but not taken
    rx_data = 8'h55; rx_data_valid = 1'b1;
    tick(); tick();
    check("hold_ready", {31'd0, rx_data_ready}, 32'd0);
    rd(5'd0, 8'h11, "hold_buf0");
    frm_release = 1'b1;
    tick();
    frm_release = 1'b0;
    check("hold_ready_after_rel", {31'd0, rx_data_ready}, 32'd1);
    tick();
    rx_data_valid = 1'b0;
    check("hold_55_no_err", {31'd0, frm_err}, 32'd0);

    // checksum error then a good one-byte frame
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h68);
    check("t2_err",   {31'd0, frm_err}, 32'd1);
    check("t2_code",  {30'd0, frm_err_code}, 32'd2);
    check("t2_done",  {31'd0, frm_done}, 32'd0);
    check("t2_ready", {31'd0, rx_data_ready}, 32'd1);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    check("t2b_done", {31'd0, frm_done}, 32'd1);
    check("t2b_len",  {24'd0, frm_len}, 32'd1);
    check("t2b_code_held", {30'd0, frm_err_code}, 32'd2);
    rd(5'd0, 8'h7E, "t2b_buf0");
    release_frame();

    // bad lengths: zero and MAX_LEN+1
    send(8'hA5); send(8'h00);
    check("t3_err0",  {31'd0, frm_err}, 32'd1);
    check("t3_code0", {30'd0, frm_err_code}, 32'd1);
    send(8'hA5); send(8'h21);
    check("t3_err33",  {31'd0, frm_err}, 32'd1);
    check("t3_code33", {30'd0, frm_err_code}, 32'd1);
    send(8'hA5); send(8'h01); send(8'h05); send(8'h06);
    check("t3_hunt_done", {31'd0, frm_done}, 32'd1);
    release_frame();

    // truncation by idle ack
    send(8'hA5); send(8'h03); send(8'h11);
    rx_frame_ack = 1'b1;
    tick();
    rx_frame_ack = 1'b0;
    check("t4_err",  {31'd0, frm_err}, 32'd1);
    check("t4_code", {30'd0, frm_err_code}, 32'd3);
    // ack in hunt is ignored
    rx_frame_ack = 1'b1;
    tick();
    rx_frame_ack = 1'b0;
    check("t4_hunt_ack", {31'd0, frm_err}, 32'd0);
    // ack coincident with the completing checksum byte
    send(8'hA5); send(8'h01); send(8'h10);
    rx_frame_ack = 1'b1;
    send(8'h11);
    rx_frame_ack = 1'b0;
    check("t4_coinc_done", {31'd0, frm_done}, 32'd1);
    check("t4_coinc_err",  {31'd0, frm_err}, 32'd0);
    check("t4_code_held",  {30'd0, frm_err_code}, 32'd3);
    release_frame();

    // reset mid-frame
    send(8'hA5); send(8'h05); send(8'h11); send(8'h22);
    #2; rst_n = 1'b0; #1;
    check("t6_rst_ready", {31'd0, rx_data_ready}, 32'd0);
    check("t6_rst_len",   {24'd0, frm_len}, 32'd0);
    check("t6_rst_code",  {30'd0, frm_err_code}, 32'd0);
    check("t6_rst_rd",    {24'd0, frm_rd_data}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    send(8'hA5); send(8'h01); send(8'hAA); send(8'hAB);
    check("t6_done", {31'd0, frm_done}, 32'd1);
    check("t6_len",  {24'd0, frm_len}, 32'd1);
    tick();
`ifdef UART_RX_FRAME_CTRL_STATS_EN
    check("t6_good_cnt", {16'd0, good_cnt}, 32'd1);
    check("t6_err_cnt",  {16'd0, err_cnt}, 32'd0);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr_good", {16'd0, good_cnt}, 32'd0);
`endif
    rd(5'd0, 8'hAA, "t6_buf0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
